unified_mem_arbiter: RTL and testbench

Arbiter and access sequencer that shares one single-ported, fixed-latency unified memory between the pipelined CPU's instruction-fetch port (IF stage) and data port (MEM stage). It serialises accesses, gives the data port priority, and counts memory latency. It returns read data through registered per-port buffers and drives per-port stall signals into the pipeline's `pc_write` / `IF_ID_write` and stall logic.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/latency_timer.sv | 40 ++++
 rtl/unified_mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory arbiter: FSM states,
// default memory latency and the grant-owner encoding.
package mem_arb_pkg;

    localparam int unsigned DefaultMemLatency = 2;

    typedef enum logic [1:0] {
        StIdle,
        StGrantIf,
        StGrantD,
        StDone
    } arb_state_e;

    localparam logic OwnerIf = 1'b0;
    localparam logic OwnerD  = 1'b1;

endpackage

// File: rtl/latency_timer.sv
// Loadable down-counter that tracks how many cycles remain before the
// memory read data is valid.
module latency_timer
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = DefaultMemLatency,
    localparam int unsigned CntW       = $clog2(MEM_LATENCY + 1)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            load,
    input  logic            dec,
    output logic [CntW-1:0] value,
    output logic            expired
);

    logic [CntW-1:0] value_q, value_d;

    // Load wins over decrement; the count saturates at zero.
    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = CntW'(MEM_LATENCY);
        end else if (dec && (value_q != '0)) begin
            value_d = value_q - CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value   = value_q;
    assign expired = (value_q == '0);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Serialises fetch and data accesses onto one fixed-latency memory port,
// data port first, with registered read-data buffers and stall outputs.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned MEM_LATENCY = DefaultMemLatency
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              d_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CntW = $clog2(MEM_LATENCY + 1);

    arb_state_e        state_q, state_d;
    logic              mem_en_q, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              if_ready_q, d_ready_q;
    logic [DATA_W-1:0] if_rdata_q, d_rdata_q;

    logic              if_elig, d_elig;
    logic              grant, owner;
    logic              cap_if, cap_d, wr_done, dec;
    logic              expired;
    logic [CntW-1:0]   unused_timer_value;

    // A port whose ready pulse is high this cycle is still holding its old
    // request; ignore it so the access is not issued twice.
    assign if_elig = if_req & ~if_ready_q;
    assign d_elig  = d_req & ~d_ready_q;

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        owner   = OwnerIf;
        cap_if  = 1'b0;
        cap_d   = 1'b0;
        wr_done = 1'b0;
        dec     = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (d_elig) begin
                    grant   = 1'b1;
                    owner   = OwnerD;
                    state_d = StGrantD;
                end else if (if_elig) begin
                    grant   = 1'b1;
                    owner   = OwnerIf;
                    state_d = StGrantIf;
                end else begin
                    state_d = StIdle;
                end
            end
            StGrantIf: begin
                if (expired) begin
                    cap_if  = 1'b1;
                    state_d = StDone;
                end else begin
                    dec = 1'b1;
                end
            end
            StGrantD: begin
                // mem_we_q is only meaningful in the first grant cycle, which
                // is the only cycle a write spends here.
                if (mem_we_q) begin
                    wr_done = 1'b1;
                    state_d = StDone;
                end else if (expired) begin
                    cap_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    dec = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    latency_timer #(
        .MEM_LATENCY (MEM_LATENCY)
    ) u_latency_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (grant),
        .dec     (dec),
        .value   (unused_timer_value),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q    <= state_d;
            mem_en_q   <= grant;
            mem_we_q   <= grant & (owner == OwnerD) & d_we;
            if_ready_q <= cap_if;
            d_ready_q  <= cap_d | wr_done;
            if (grant) begin
                mem_addr_q <= (owner == OwnerD) ? d_addr : if_addr;
            end
            if (grant && (owner == OwnerD)) begin
                mem_wdata_q <= d_wdata;
            end
            if (cap_if) begin
                if_rdata_q <= mem_rdata;
            end
            if (cap_d) begin
                d_rdata_q <= mem_rdata;
            end
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_ready  = if_ready_q;
    assign d_ready   = d_ready_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_stall  = if_req & ~if_ready_q;
    assign d_stall   = d_req & ~d_ready_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter with a 2-cycle memory model.
module tb_unified_mem_arbiter;

    typedef struct {
        int          cyc;
        logic [15:0] data;
    } rsp_t;

    typedef struct {
        int          cyc;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } macc_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_ready;
    logic        if_stall;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic [15:0] d_rdata;
    logic        d_ready;
    logic        d_stall;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    bit    mem_chk_en = 1'b1;
    logic  [15:0] last_d_rd = '0;
    rsp_t  if_q[$];
    rsp_t  d_q[$];
    macc_t mem_q[$];

    unified_mem_arbiter #(
        .ADDR_W      (16),
        .DATA_W      (16),
        .MEM_LATENCY (2)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .if_stall  (if_stall),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .d_stall   (d_stall),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: preloaded constants overlaid by writes, data 2 cycles after mem_en.
    logic [15:0] wmem   [1024];
    bit          wvalid [1024];
    logic [15:0] rd_p1 = '0;

    function automatic logic [15:0] preload(input logic [9:0] a);
        case (a)
            10'h010: return 16'hABCD;
            10'h004: return 16'h1111;
            10'h100: return 16'h5A5A;
            10'h030: return 16'hBEEF;
            10'h040: return 16'h7777;
            default: return {6'h00, a} ^ 16'h3C00;
        endcase
    endfunction

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        return wvalid[a[9:0]] ? wmem[a[9:0]] : preload(a[9:0]);
    endfunction

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            wmem[mem_addr[9:0]]   <= mem_wdata;
            wvalid[mem_addr[9:0]] <= 1'b1;
        end
        rd_p1     <= mem_rd(mem_addr);
        mem_rdata <= rd_p1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents an access or a completion.
    logic prev_en = 1'b0;
    always @(negedge clk) begin
        rsp_t  r;
        macc_t m;
        if (!reset_n) begin
            prev_en = 1'b0;
        end else begin
            if (mem_en) begin
                chk("mem_en_back_to_back", {31'd0, prev_en}, 32'd0);
                if (mem_chk_en) begin
                    if (mem_q.size() == 0) begin
                        chk("unexpected_mem_en", 32'd1, 32'd0);
                    end else begin
                        m = mem_q.pop_front();
                        if (m.cyc >= 0) chk("mem_en_cycle", cyc, m.cyc);
                        chk("mem_we", {31'd0, mem_we}, {31'd0, m.we});
                        chk("mem_addr", {16'd0, mem_addr}, {16'd0, m.addr});
                        if (m.we) chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, m.wdata});
                    end
                end
            end
            prev_en = mem_en;
            if (if_ready) begin
                if (if_q.size() == 0) begin
                    chk("unexpected_if_ready", 32'd1, 32'd0);
                end else begin
                    r = if_q.pop_front();
                    if (r.cyc >= 0) chk("if_ready_cycle", cyc, r.cyc);
                    chk("if_rdata", {16'd0, if_rdata}, {16'd0, r.data});
                end
            end
            if (d_ready) begin
                if (d_q.size() == 0) begin
                    chk("unexpected_d_ready", 32'd1, 32'd0);
                end else begin
                    r = d_q.pop_front();
                    if (r.cyc >= 0) chk("d_ready_cycle", cyc, r.cyc);
                    chk("d_rdata", {16'd0, d_rdata}, {16'd0, r.data});
                end
            end
        end
    end

    // Issue a fetch; rdy_lat / men_lat < 0 means that timing is not checked.
    task automatic fetch(input logic [15:0] addr, input int rdy_lat, input int men_lat);
        int    c0;
        bit    got;
        rsp_t  e;
        macc_t m;
        c0      = cyc;
        if_addr = addr;
        if_req  = 1'b1;
        e.cyc   = (rdy_lat < 0) ? -1 : c0 + rdy_lat;
        e.data  = mem_rd(addr);
        if_q.push_back(e);
        if (men_lat >= 0) begin
            m.cyc = c0 + men_lat; m.we = 1'b0; m.addr = addr; m.wdata = '0;
            mem_q.push_back(m);
        end
        #1 chk("if_stall_wait", {31'd0, if_stall}, 32'd1);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            if (if_ready) begin
                got = 1'b1;
                chk("if_stall_done", {31'd0, if_stall}, 32'd0);
            end else begin
                chk("if_stall_wait", {31'd0, if_stall}, 32'd1);
            end
        end
        if (!got) chk("if_ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    task automatic dacc(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                        input int rdy_lat, input int men_lat);
        int    c0;
        bit    got;
        rsp_t  e;
        macc_t m;
        c0      = cyc;
        d_we    = we;
        d_addr  = addr;
        d_wdata = wdata;
        d_req   = 1'b1;
        if (!we) last_d_rd = mem_rd(addr);
        e.cyc  = (rdy_lat < 0) ? -1 : c0 + rdy_lat;
        e.data = last_d_rd;
        d_q.push_back(e);
        if (men_lat >= 0) begin
            m.cyc = c0 + men_lat; m.we = we; m.addr = addr; m.wdata = wdata;
            mem_q.push_back(m);
        end
        #1 chk("d_stall_wait", {31'd0, d_stall}, 32'd1);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            if (d_ready) begin
                got = 1'b1;
                chk("d_stall_done", {31'd0, d_stall}, 32'd0);
            end
        end
        if (!got) chk("d_ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        d_req = 1'b0;
        d_we  = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_mem_en"},    {31'd0, mem_en},    32'd0);
        chk({tag, "_mem_we"},    {31'd0, mem_we},    32'd0);
        chk({tag, "_mem_addr"},  {16'd0, mem_addr},  32'd0);
        chk({tag, "_mem_wdata"}, {16'd0, mem_wdata}, 32'd0);
        chk({tag, "_if_ready"},  {31'd0, if_ready},  32'd0);
        chk({tag, "_d_ready"},   {31'd0, d_ready},   32'd0);
        chk({tag, "_if_rdata"},  {16'd0, if_rdata},  32'd0);
        chk({tag, "_d_rdata"},   {16'd0, d_rdata},   32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        macc_t m;
        int    c0;
        reset_n = 1'b0;
        if_req  = 1'b0;
        if_addr = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        idle(3);
        check_outputs_zero("reset");
        chk("reset_if_stall", {31'd0, if_stall}, 32'd0);
        reset_n = 1'b1;
        idle(2);

        // Fetch read: mem_en at +1, ready with 0xABCD at +4.
        fetch(16'h0010, 4, 1);
        idle(2);

        // Collision: data first (mem_en +1, ready +4), fetch after (mem_en +5, ready +8).
        m.cyc = cyc + 1; m.we = 1'b0; m.addr = 16'h0100; m.wdata = '0;
        mem_q.push_back(m);
        m.cyc = cyc + 5; m.we = 1'b0; m.addr = 16'h0004; m.wdata = '0;
        mem_q.push_back(m);
        fork
            fetch(16'h0004, 8, -1);
            dacc(1'b0, 16'h0100, 16'h0000, 4, -1);
        join
        idle(2);

        // Store: mem_en/mem_we at +1, d_ready at +2, d_rdata keeps 0x5A5A.
        dacc(1'b1, 16'h0020, 16'h1234, 2, 1);
        idle(1);
        chk("store_in_memory", {16'd0, mem_rd(16'h0020)}, 32'h0000_1234);
        dacc(1'b0, 16'h0020, 16'h0000, 4, 1);
        idle(2);

        // Reset in cycle 2 of a fetch: outputs clear at once, no ready afterwards.
        c0      = cyc;
        if_addr = 16'h0030;
        if_req  = 1'b1;
        m.cyc = c0 + 1; m.we = 1'b0; m.addr = 16'h0030; m.wdata = '0;
        mem_q.push_back(m);
        idle(2);
        reset_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        chk("midreset_if_stall", {31'd0, if_stall}, 32'd1);
        if_req = 1'b0;
        #1 chk("midreset_if_stall_low", {31'd0, if_stall}, 32'd0);
        last_d_rd = '0;
        idle(2);
        reset_n = 1'b1;
        idle(6);
        fetch(16'h0040, 4, 1);
        idle(2);

        // Continuous fetch against store bursts with one idle cycle between stores.
        mem_chk_en = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++) fetch(16'h0300 + 16'(i), -1, -1);
            end
            begin
                for (int j = 0; j < 3; j++) begin
                    dacc(1'b1, 16'h0200 + 16'(j), 16'hC000 + 16'(j), -1, -1);
                    idle(1);
                end
            end
        join
        idle(3);
        for (int j = 0; j < 3; j++) begin
            chk("burst_store_in_memory", {16'd0, mem_rd(16'h0200 + 16'(j))},
                {16'd0, 16'hC000 + 16'(j)});
        end

        chk("if_queue_drained",  if_q.size(),  32'd0);
        chk("d_queue_drained",   d_q.size(),   32'd0);
        chk("mem_queue_drained", mem_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
